// File: rtl/rggen_apb_bit_field_adapter.sv
// rtl/rggen_apb_bit_field_adapter.sv - APB slave to register bit-field access adapter (optional macro: RGGEN_APB_BYTE_STROBE_EN)
module rggen_apb_bit_field_adapter #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int REGISTERS     = 4,
  parameter int BASE_ADDRESS  = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_psel,
  input  logic                           i_penable,
  input  logic [ADDRESS_WIDTH-1:0]       i_paddr,
  input  logic                           i_pwrite,
  input  logic [BUS_WIDTH-1:0]           i_pwdata,
  input  logic [BUS_WIDTH/8-1:0]         i_pstrb,
  output logic                           o_pready,
  output logic [BUS_WIDTH-1:0]           o_prdata,
  output logic                           o_pslverr,
  output logic [REGISTERS-1:0]           o_register_valid,
  output logic [BUS_WIDTH-1:0]           o_register_read_mask,
  output logic [BUS_WIDTH-1:0]           o_register_write_mask,
  output logic [BUS_WIDTH-1:0]           o_register_write_data,
  input  logic [REGISTERS*BUS_WIDTH-1:0] i_register_read_data
);

  localparam int LANES    = BUS_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 write_q, write_d;
  logic [REGISTERS-1:0] select_q, select_d;
  logic [BUS_WIDTH-1:0] wdata_q, wdata_d;
  logic [BUS_WIDTH-1:0] wmask_q, wmask_d;
  logic [BUS_WIDTH-1:0] rdata_q, rdata_d;

  logic [ADDRESS_WIDTH-1:0] offset;
  logic [31:0]              index;
  logic                     in_range;
  logic                     aligned;
  logic [REGISTERS-1:0]     decode_select;
  logic [BUS_WIDTH-1:0]     setup_mask;
  logic [BUS_WIDTH-1:0]     selected_rdata;

  // Address decode of the setup-phase address into a one-hot register select (all zero on a miss)
  always_comb begin
    offset        = i_paddr - ADDRESS_WIDTH'(BASE_ADDRESS);
    in_range      = i_paddr >= ADDRESS_WIDTH'(BASE_ADDRESS);
    aligned       = (offset & ADDRESS_WIDTH'(LANES - 1)) == '0;
    index         = 32'(offset >> ADDR_LSB);
    decode_select = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      decode_select[i] = in_range && aligned && (index == 32'(i));
    end
  end

`ifdef RGGEN_APB_BYTE_STROBE_EN
  // Byte-lane write mask expanded from the APB strobes
  always_comb begin
    setup_mask = '0;
    for (int k = 0; k < LANES; k++) begin
      setup_mask[k*8 +: 8] = {8{i_pstrb[k]}};
    end
  end
`else
  logic unused_pstrb;
  assign unused_pstrb = ^i_pstrb;

  // Without strobes every write covers the whole word
  always_comb begin
    setup_mask = '1;
  end
`endif

  // Read-data mux over the flattened slices; zero when nothing is selected
  always_comb begin
    selected_rdata = '0;
    for (int i = 0; i < REGISTERS; i++) begin
      if (select_q[i]) begin
        selected_rdata = selected_rdata | i_register_read_data[i*BUS_WIDTH +: BUS_WIDTH];
      end
    end
  end

  // FSM next state, setup capture and per-state outputs
  always_comb begin
    state_d               = state_q;
    write_d               = write_q;
    select_d              = select_q;
    wdata_d               = wdata_q;
    wmask_d               = wmask_q;
    rdata_d               = rdata_q;
    o_pready              = 1'b0;
    o_pslverr             = 1'b0;
    o_prdata              = '0;
    o_register_valid      = '0;
    o_register_read_mask  = '0;
    o_register_write_mask = '0;
    case (state_q)
      IDLE: begin
        if (i_psel && !i_penable) begin
          state_d  = ACCESS;
          write_d  = i_pwrite;
          select_d = decode_select;
          wdata_d  = i_pwdata;
          wmask_d  = i_pwrite ? setup_mask : '0;
        end
      end
      ACCESS: begin
        o_register_valid = select_q;
        if (|select_q) begin
          o_register_read_mask  = write_q ? '0 : '1;
          o_register_write_mask = wmask_q;
        end
        // Sampled here so a read side-effect on this edge is not observed
        rdata_d = selected_rdata;
        state_d = i_psel ? RESPOND : IDLE;
      end
      RESPOND: begin
        o_pready  = 1'b1;
        o_pslverr = ~|select_q;
        o_prdata  = write_q ? '0 : rdata_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_register_write_data = wdata_q;

  // State and capture registers with asynchronous reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      select_q <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      select_q <= select_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_rggen_apb_bit_field_adapter.sv
// tb/tb_rggen_apb_bit_field_adapter.sv - self-checking bench for rggen_apb_bit_field_adapter
module tb_rggen_apb_bit_field_adapter;

  localparam int NR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          psel, penable, pwrite;
  logic [7:0]    paddr;
  logic [31:0]   pwdata;
  logic [3:0]    pstrb;
  logic          pready, pslverr;
  logic [31:0]   prdata;
  logic [NR-1:0] valid;
  logic [31:0]   rmask, wmask, wdata;
  logic [NR*32-1:0] rdata_flat;
  logic [31:0]   rf [NR];

  int errors = 0;
  int checks = 0;
  int valid_cycles = 0;

  always #5 clk = ~clk;

  rggen_apb_bit_field_adapter #(
    .ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTERS(NR), .BASE_ADDRESS(0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_psel(psel), .i_penable(penable),
    .i_paddr(paddr), .i_pwrite(pwrite), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(pready), .o_prdata(prdata), .o_pslverr(pslverr),
    .o_register_valid(valid), .o_register_read_mask(rmask),
    .o_register_write_mask(wmask), .o_register_write_data(wdata),
    .i_register_read_data(rdata_flat)
  );

  always_comb begin
    rdata_flat = '0;
    for (int i = 0; i < NR; i++) rdata_flat[i*32 +: 32] = rf[i];
  end

  // Bit-field model: register 2 is read-clear, all others are plain RW with mask
  always @(posedge clk) begin
    for (int i = 0; i < NR; i++) begin
      if (valid[i]) begin
        if (rmask != 0) begin
          if (i == 2) rf[i] <= '0;
        end else begin
          rf[i] <= (rf[i] & ~wmask) | (wdata & wmask);
        end
      end
    end
  end

  always @(negedge clk) if (valid != 0) valid_cycles++;

  typedef struct {
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [3:0]  exp_valid;
    logic [31:0] exp_wmask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb[$];
  vec_t  vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic xfer(input vec_t v);
    int    cyc;
    int    vc0;
    resp_t r;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = v.addr; pwrite = v.wr; pwdata = v.wdata; pstrb = v.strb;
    sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
    vc0 = valid_cycles;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr = 8'hEE; pwdata = ~v.wdata; pstrb = ~v.strb;
    @(negedge clk);
    chk("access_valid", 64'(valid), 64'(v.exp_valid));
    chk("access_wmask", 64'(wmask), 64'(v.exp_wmask));
    chk("access_rmask", 64'(rmask), (v.exp_valid != 0 && !v.wr) ? 64'hFFFF_FFFF : 64'h0);
    if (v.wr && v.exp_valid != 0) chk("access_wdata", 64'(wdata), 64'(v.wdata));
    chk("access_pready", 64'(pready), 64'h0);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!pready && cyc < 4);
    chk("latency", 64'(cyc), 64'd1);
    if (pready) begin
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 64'd1, 64'd0);
      end else begin
        r = sb.pop_front();
        chk("prdata", 64'(prdata), 64'(r.rdata));
        chk("pslverr", 64'(pslverr), 64'(r.err));
      end
      chk("respond_valid", 64'(valid), 64'h0);
    end else begin
      void'(sb.pop_front());
    end
    chk("valid_pulses", 64'(valid_cycles - vc0), (v.exp_valid != 0) ? 64'd1 : 64'd0);
  endtask

  initial begin
    int vc0;
    int pr_cnt;
    logic [31:0] strb_mask5, rd0_after, strb0_mask, rd3_after;
`ifdef RGGEN_APB_BYTE_STROBE_EN
    strb_mask5 = 32'h00FF_00FF; rd0_after = 32'h0022_0044;
    strb0_mask = 32'h0000_0000; rd3_after = 32'h1234_5678;
`else
    strb_mask5 = 32'hFFFF_FFFF; rd0_after = 32'h1122_3344;
    strb0_mask = 32'hFFFF_FFFF; rd3_after = 32'hDEAD_BEEF;
`endif
    vecs.push_back('{8'h04, 1'b1, 32'hA5A5_0F0F, 4'hF, 4'b0010, 32'hFFFF_FFFF, 32'h0,         1'b0});
    vecs.push_back('{8'h04, 1'b0, 32'h0,         4'hF, 4'b0010, 32'h0,         32'hA5A5_0F0F, 1'b0});
    vecs.push_back('{8'h0C, 1'b0, 32'h0,         4'hF, 4'b1000, 32'h0,         32'h1234_5678, 1'b0});
    vecs.push_back('{8'h08, 1'b0, 32'h0,         4'hF, 4'b0100, 32'h0,         32'h0000_00FF, 1'b0});
    vecs.push_back('{8'h08, 1'b0, 32'h0,         4'hF, 4'b0100, 32'h0,         32'h0,         1'b0});
    vecs.push_back('{8'h10, 1'b0, 32'h0,         4'hF, 4'b0000, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{8'h02, 1'b0, 32'h0,         4'hF, 4'b0000, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{8'h10, 1'b1, 32'hFFFF_FFFF, 4'hF, 4'b0000, 32'h0,         32'h0,         1'b1});
    vecs.push_back('{8'h00, 1'b1, 32'h1122_3344, 4'h5, 4'b0001, strb_mask5,    32'h0,         1'b0});
    vecs.push_back('{8'h00, 1'b0, 32'h0,         4'hF, 4'b0001, 32'h0,         rd0_after,     1'b0});
    vecs.push_back('{8'h0C, 1'b1, 32'hDEAD_BEEF, 4'h0, 4'b1000, strb0_mask,    32'h0,         1'b0});
    vecs.push_back('{8'h0C, 1'b0, 32'h0,         4'hF, 4'b1000, 32'h0,         rd3_after,     1'b0});
    vecs.push_back('{8'h0F, 1'b1, 32'h5555_5555, 4'hF, 4'b0000, 32'h0,         32'h0,         1'b1});

    rf[0] = 32'h0; rf[1] = 32'h0; rf[2] = 32'h0000_00FF; rf[3] = 32'h1234_5678;
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pready", 64'(pready), 64'h0);
    chk("reset_pslverr", 64'(pslverr), 64'h0);
    chk("reset_prdata", 64'(prdata), 64'h0);
    chk("reset_valid", 64'(valid), 64'h0);
    chk("reset_masks", 64'(rmask | wmask | wdata), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) xfer(vecs[i]);

    // Reset asserted in the middle of a write ACCESS
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 8'h04; pwrite = 1'b1; pwdata = 32'h0BAD_F00D; pstrb = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    #2;
    chk("pre_reset_valid", 64'(valid), 64'b0010);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(valid), 64'h0);
    chk("midrst_pready", 64'(pready), 64'h0);
    chk("midrst_prdata", 64'(prdata), 64'h0);
    chk("midrst_outs", 64'(rmask | wmask | wdata), 64'h0);
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    vc0 = valid_cycles;
    repeat (3) @(negedge clk);
    chk("no_stray_valid", 64'(valid_cycles - vc0), 64'd0);
    xfer('{8'h04, 1'b0, 32'h0, 4'hF, 4'b0010, 32'h0, 32'hA5A5_0F0F, 1'b0});

    // psel dropped during ACCESS: valid still pulses once, no pready
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; paddr = 8'h0C; pwrite = 1'b1; pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
    vc0 = valid_cycles;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("abort_valid", 64'(valid), 64'b1000);
    pr_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (pready) pr_cnt++;
    end
    chk("abort_no_pready", 64'(pr_cnt), 64'd0);
    chk("abort_pulses", 64'(valid_cycles - vc0), 64'd1);
    xfer('{8'h0C, 1'b0, 32'h0, 4'hF, 4'b1000, 32'h0, 32'hCAFE_F00D, 1'b0});

    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
